lcd_reader: RTL and testbench

//  HD44780 bus reader: the read-side companion of the LCD write engine on the same
//  8-bit bus. On a host request it polls the busy flag, then performs one read
//  (RS=1 DDRAM/CGRAM data, RS=0 busy flag + address counter).
//  It returns the byte with a one-cycle ack. The system muxes e/rw/rs between

---
 rtl/lcd_bus_pkg.sv | 36 +++
 rtl/lcd_strobe.sv | 84 ++++++++
 rtl/lcd_reader.sv | 187 ++++++++++++++++++
 tb/tb_lcd_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared HD44780 bus definitions for the LCD reader and write engine.
package lcd_bus_pkg;

  localparam int unsigned BUS_W = 8;

  localparam logic LOW      = 1'b0;
  localparam logic HIGH     = 1'b1;
  localparam logic RS_CMD   = 1'b0;
  localparam logic RS_DATA  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BF_SETUP,
    BF_EHI,
    BF_ELO,
    RD_SETUP,
    RD_EHI,
    RD_ELO,
    ACK
  } rd_state_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_SETUP,
    STB_EHI,
    STB_ELO
  } stb_phase_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_strobe.sv
// One bus access: setup, E high, E low, timed by a single down-counter.
// All three cycle counts must be at least 1.
module lcd_strobe
  import lcd_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned E_HIGH_CYCLES = 2,
  parameter int unsigned E_LOW_CYCLES  = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  output logic e,
  output logic sample_o,
  output logic done_o
);

  localparam int unsigned MAX_CYC =
    (SETUP_CYCLES > E_HIGH_CYCLES) ?
      ((SETUP_CYCLES > E_LOW_CYCLES) ? SETUP_CYCLES : E_LOW_CYCLES) :
      ((E_HIGH_CYCLES > E_LOW_CYCLES) ? E_HIGH_CYCLES : E_LOW_CYCLES);
  localparam int unsigned CNT_W = cnt_width(MAX_CYC);

  stb_phase_t       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_d;

  // Sample/done mark the last cycle of E-high and E-low; decoded from flops only.
  assign sample_o = (phase_q == STB_EHI) && (cnt_q == '0);
  assign done_o   = (phase_q == STB_ELO) && (cnt_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= STB_IDLE;
      cnt_q   <= '0;
      e       <= LOW;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e       <= e_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e;
    if (start_i) begin
      phase_d = STB_SETUP;
      cnt_d   = CNT_W'(SETUP_CYCLES - 1);
      e_d     = LOW;
    end else begin
      case (phase_q)
        STB_SETUP: begin
          if (cnt_q == '0) begin
            phase_d = STB_EHI;
            cnt_d   = CNT_W'(E_HIGH_CYCLES - 1);
            e_d     = HIGH;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        STB_EHI: begin
          if (cnt_q == '0) begin
            phase_d = STB_ELO;
            cnt_d   = CNT_W'(E_LOW_CYCLES - 1);
            e_d     = LOW;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        STB_ELO: begin
          if (cnt_q == '0) begin
            phase_d = STB_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 bus reader: polls the busy flag, then reads one data or status byte.
// Optional busy-poll timeout enabled by defining LCD_READ_TIMEOUT_EN.
module lcd_reader
  import lcd_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned E_HIGH_CYCLES = 2,
  parameter int unsigned E_LOW_CYCLES  = 2
`ifdef LCD_READ_TIMEOUT_EN
  , parameter int unsigned BF_TIMEOUT  = 1023
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req,
  input  logic             register,
  output logic             ack,
  output logic [BUS_W-1:0] value,
  output logic             err,
  output logic             e,
  output logic             rw,
  output logic             rs,
  inout  wire  [BUS_W-1:0] data
);

  rd_state_t        state_q, state_d;
  logic             ack_d, rw_d, rs_d;
  logic [BUS_W-1:0] value_d;
  logic             bf_q, bf_d;
  logic             reg_q, reg_d;
  logic             start_c;
  logic             strobe_sample;
  logic             strobe_done;

  // The reader only ever listens on the bus.
  assign data = {BUS_W{1'bz}};

  lcd_strobe #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .E_HIGH_CYCLES(E_HIGH_CYCLES),
    .E_LOW_CYCLES (E_LOW_CYCLES)
  ) u_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (start_c),
    .e       (e),
    .sample_o(strobe_sample),
    .done_o  (strobe_done)
  );

`ifdef LCD_READ_TIMEOUT_EN
  localparam int unsigned POLL_W = cnt_width(BF_TIMEOUT);
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_q <= '0;
      err    <= LOW;
    end else begin
      poll_q <= poll_d;
      err    <= err_d;
    end
  end
`else
  assign err = LOW;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack     <= LOW;
      rw      <= RW_WRITE;
      rs      <= RS_CMD;
      value   <= '0;
      bf_q    <= LOW;
      reg_q   <= RS_CMD;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
      rw      <= rw_d;
      rs      <= rs_d;
      value   <= value_d;
      bf_q    <= bf_d;
      reg_q   <= reg_d;
    end
  end

  // Sequencer: busy poll(s), one read, one-cycle ack. Strobe timing lives in lcd_strobe.
  always_comb begin
    state_d = state_q;
    ack_d   = LOW;
    rw_d    = rw;
    rs_d    = rs;
    value_d = value;
    bf_d    = bf_q;
    reg_d   = reg_q;
    start_c = LOW;
`ifdef LCD_READ_TIMEOUT_EN
    err_d   = LOW;
    poll_d  = poll_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          reg_d   = register;
          rw_d    = RW_READ;
          rs_d    = RS_CMD;
          start_c = HIGH;
          state_d = BF_SETUP;
`ifdef LCD_READ_TIMEOUT_EN
          poll_d  = '0;
`endif
        end
      end
      BF_SETUP: begin
        if (strobe_sample) begin
          bf_d    = data[BUS_W-1];
          state_d = BF_ELO;
        end else if (e) begin
          state_d = BF_EHI;
        end
      end
      BF_EHI: begin
        if (strobe_sample) begin
          bf_d    = data[BUS_W-1];
          state_d = BF_ELO;
        end
      end
      BF_ELO: begin
        if (strobe_done) begin
          if (bf_q) begin
`ifdef LCD_READ_TIMEOUT_EN
            if (poll_q == POLL_W'(BF_TIMEOUT - 1)) begin
              ack_d   = HIGH;
              err_d   = HIGH;
              rw_d    = RW_WRITE;
              rs_d    = RS_CMD;
              state_d = ACK;
            end else begin
              poll_d  = poll_q + 1'b1;
              start_c = HIGH;
              state_d = BF_SETUP;
            end
`else
            start_c = HIGH;
            state_d = BF_SETUP;
`endif
          end else begin
            rs_d    = reg_q;
            start_c = HIGH;
            state_d = RD_SETUP;
          end
        end
      end
      RD_SETUP: begin
        if (strobe_sample) begin
          value_d = data;
          state_d = RD_ELO;
        end else if (e) begin
          state_d = RD_EHI;
        end
      end
      RD_EHI: begin
        if (strobe_sample) begin
          value_d = data;
          state_d = RD_ELO;
        end
      end
      RD_ELO: begin
        if (strobe_done) begin
          ack_d   = HIGH;
          rw_d    = RW_WRITE;
          rs_d    = RS_CMD;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader with a small HD44780 read-side bus model.
module tb_lcd_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req;
  logic       register;
  logic       ack;
  logic [7:0] value;
  logic       err;
  logic       e;
  logic       rw;
  logic       rs;
  wire  [7:0] data;

  typedef struct {
    int unsigned exp_cyc;
    logic [7:0]  value;
    logic        err;
    int unsigned pulses;
    int unsigned rs_pulses;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned cyc        = 0;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // LCD model
  logic [7:0]  rd_byte   = 8'h41;
  logic [6:0]  ac        = 7'h00;
  int unsigned busy_left = 0;
  logic        bf_stuck  = 1'b0;
  logic        model_e_prev = 1'b0;
  logic        lcd_drive;
  logic [7:0]  lcd_byte;

  assign lcd_drive = e & rw;
  assign lcd_byte  = rs ? rd_byte : {((busy_left != 0) | bf_stuck), ac};
  assign data      = lcd_drive ? lcd_byte : 8'bz;

  lcd_reader #(
    .SETUP_CYCLES (1),
    .E_HIGH_CYCLES(2),
    .E_LOW_CYCLES (2)
`ifdef LCD_READ_TIMEOUT_EN
    , .BF_TIMEOUT (4)
`endif
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .register(register),
    .ack     (ack),
    .value   (value),
    .err     (err),
    .e       (e),
    .rw      (rw),
    .rs      (rs),
    .data    (data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Busy flag clears one poll at a time, after the poll's strobe ends.
  always @(negedge clock) begin
    if (model_e_prev && !e && !rs && busy_left != 0) busy_left = busy_left - 1;
    model_e_prev = e;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts E pulses and compares every ack against the scoreboard.
  logic        mon_e_prev = 1'b0;
  int unsigned pulses     = 0;
  int unsigned rs_pulses  = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      pulses    = 0;
      rs_pulses = 0;
    end else begin
      if (e && !mon_e_prev) begin
        pulses = pulses + 1;
        if (rs) rs_pulses = rs_pulses + 1;
        check("rw_during_e", 32'(rw), 32'd1);
      end
      if (ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          cur = sb.pop_front();
          check("ack_cycle", cyc, cur.exp_cyc);
          check("value", 32'(value), 32'(cur.value));
          check("err", 32'(err), 32'(cur.err));
          check("e_pulses", pulses, cur.pulses);
          check("rs1_pulses", rs_pulses, cur.rs_pulses);
          check("rw_at_ack", 32'(rw), 32'd0);
        end
        pulses    = 0;
        rs_pulses = 0;
      end
    end
    mon_e_prev = e;
  end

  task automatic push(input int unsigned at, input logic [7:0] v, input logic er,
                      input int unsigned p, input int unsigned rp);
    exp_t x;
    x.exp_cyc   = at;
    x.value     = v;
    x.err       = er;
    x.pulses    = p;
    x.rs_pulses = rp;
    sb.push_back(x);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n = n + 1;
    end
    if (sb.size() != 0) begin
      check("ack_wait_expired", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // One request; called at a negedge, so the accept edge k is cyc+1.
  task automatic issue(input logic r, input int unsigned lat, input logic [7:0] v,
                       input logic er, input int unsigned p, input int unsigned rp);
    int unsigned k;
    k = cyc + 1;
    push(k + lat, v, er, p, rp);
    register = r;
    req      = 1'b1;
    @(negedge clock);
    req      = 1'b0;
    register = ~r;
    wait_done(200);
  endtask

  initial begin
    int unsigned k;
    int unsigned n;
    reset_n  = 1'b0;
    req      = 1'b0;
    register = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_e", 32'(e), 32'd0);
    check("reset_rw", 32'(rw), 32'd0);
    check("reset_rs", 32'(rs), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_value", 32'(value), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Plain data read, no busy.
    rd_byte = 8'h41;
    issue(1'b1, 10, 8'h41, 1'b0, 2, 1);

    // Busy for three polls.
    rd_byte   = 8'h5a;
    busy_left = 3;
    issue(1'b1, 25, 8'h5a, 1'b0, 5, 1);

    // Status/address read.
    rd_byte = 8'h99;
    ac      = 7'h25;
    issue(1'b0, 10, 8'h25, 1'b0, 2, 0);

    // Reset during the read's E-high phase.
    rd_byte  = 8'h41;
    register = 1'b1;
    req      = 1'b1;
    @(negedge clock);
    req = 1'b0;
    n   = 0;
    while (!(e && rs) && n < 50) begin
      @(negedge clock);
      n = n + 1;
    end
    check("reached_read_e_high", 32'(e && rs), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_e", 32'(e), 32'd0);
    check("midrst_rw", 32'(rw), 32'd0);
    check("midrst_rs", 32'(rs), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_value", 32'(value), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    issue(1'b1, 10, 8'h41, 1'b0, 2, 1);

    // req held high: back-to-back reads.
    rd_byte  = 8'h41;
    register = 1'b1;
    k        = cyc + 1;
    push(k + 10, 8'h41, 1'b0, 2, 1);
    push(k + 22, 8'h42, 1'b0, 2, 1);
    req = 1'b1;
    repeat (12) @(negedge clock);
    rd_byte = 8'h42;
    @(negedge clock);
    req = 1'b0;
    wait_done(200);

`ifdef LCD_READ_TIMEOUT_EN
    // Busy flag stuck: four polls then abort; value keeps the last read.
    bf_stuck = 1'b1;
    rd_byte  = 8'h77;
    issue(1'b1, 20, 8'h42, 1'b1, 4, 0);
    bf_stuck = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
